// File: rtl/student_tlul_sram_adapter.sv
// student_tlul_sram_adapter
// TL-UL device adapter in front of a single-port word SRAM with a one-cycle
// read latency. It accepts one request at a time, checks it for legality,
// issues at most one memory access per request and holds a single D-channel
// response until the host takes it.
//
// Ports
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   tl_i         A-channel request fields and d_ready from the mux device port
//   tl_o         a_ready and D-channel response fields to the mux device port
//   mem_req_o    memory access strobe, one cycle per access
//   mem_we_o     1 = write, 0 = read
//   mem_addr_o   word address
//   mem_wdata_o  write data
//   mem_be_o     byte enables (a_mask on writes, all ones on reads)
//   mem_rdata_i  read data, valid the cycle after a read strobe

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

// state   | meaning
// IDLE    | ready for a request (a_ready high unless in reset)
// RD_WAIT | memory read issued, capturing read data this cycle
// RESP    | response presented on D, held until d_ready
module student_tlul_sram_adapter #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_OFFSET = 20,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  output logic [3:0]         mem_be_o,
  input  logic [31:0]        mem_rdata_i
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP    = 2'd2;

  // Address bits inside the device window but above the memory must be zero.
  localparam logic [63:0] WIN_MASK = (64'd1 << ADDR_OFFSET) - 64'd1;
  localparam logic [63:0] MEM_MASK = (64'd1 << (AW + 2)) - 64'd1;
  localparam logic [31:0] HI_MASK  = 32'(WIN_MASK & ~MEM_MASK);

  logic [1:0]  r_state;
  logic [2:0]  r_d_opcode;
  logic        r_d_error;
  logic [31:0] r_d_data;
  logic [7:0]  r_d_source;
  logic [1:0]  r_d_size;

  logic w_is_get;
  logic w_is_put;
  logic w_legal;
  logic w_a_ready;
  logic w_accept;
  logic w_unused;

  assign w_unused = ^tl_i.a_param;

  always_comb begin
    w_is_get = (tl_i.a_opcode == tlul_pkg::Get);
    w_is_put = (tl_i.a_opcode == tlul_pkg::PutFullData) ||
               (tl_i.a_opcode == tlul_pkg::PutPartialData);
    w_legal  = (w_is_get || w_is_put) &&
               (tl_i.a_size == 2'd2) &&
               (tl_i.a_address[1:0] == 2'b00) &&
               ((tl_i.a_address & HI_MASK) == 32'd0) &&
               !((tl_i.a_opcode == tlul_pkg::PutFullData) && (tl_i.a_mask != 4'hF)) &&
               !((tl_i.a_opcode == tlul_pkg::PutPartialData) && (tl_i.a_mask == 4'h0));
    // a_ready is gated by rst_i directly so it drops the moment reset rises.
    w_a_ready = (r_state == ST_IDLE) && !rst_i;
    w_accept  = tl_i.a_valid && w_a_ready;
  end

  // Memory strobe is combinational in the accept cycle; illegal requests never reach memory.
  always_comb begin
    mem_req_o   = w_accept && w_legal;
    mem_we_o    = w_is_put;
    mem_addr_o  = tl_i.a_address[AW+1:2];
    mem_wdata_o = tl_i.a_data;
    mem_be_o    = w_is_put ? tl_i.a_mask : 4'hF;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_d_opcode <= 3'd0;
      r_d_error  <= 1'b0;
      r_d_data   <= 32'd0;
      r_d_source <= 8'd0;
      r_d_size   <= 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_d_source <= tl_i.a_source;
            r_d_size   <= tl_i.a_size;
            r_d_error  <= !w_legal;
            r_d_data   <= 32'd0;
            // Get always answers with data, even when it is rejected.
            r_d_opcode <= w_is_get ? tlul_pkg::AccessAckData : tlul_pkg::AccessAck;
            r_state    <= (w_legal && w_is_get) ? ST_RD_WAIT : ST_RESP;
          end
        end
        ST_RD_WAIT: begin
          r_d_data <= mem_rdata_i;
          r_state  <= ST_RESP;
        end
        ST_RESP: begin
          if (tl_i.d_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = (r_state == ST_RESP);
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_param  = 3'd0;
    tl_o.d_size   = r_d_size;
    tl_o.d_source = r_d_source;
    tl_o.d_sink   = 1'b0;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
    tl_o.a_ready  = w_a_ready;
  end

endmodule

// File: tb/tb_student_tlul_sram_adapter.sv
module tb_student_tlul_sram_adapter;

  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH);

  logic clk;
  logic rst;
  tlul_pkg::tl_h2d_t tl_h2d;
  tlul_pkg::tl_d2h_t tl_d2h;
  logic              mem_req, mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [3:0]        mem_be;

  // host-side drive variables
  logic        a_valid;
  logic [2:0]  a_op;
  logic [1:0]  a_sz;
  logic [7:0]  a_src;
  logic [31:0] a_addr;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_rdy;
  bit          rnd_dready;

  int n_checks;
  int n_fail;

  always_comb begin
    tl_h2d           = '0;
    tl_h2d.a_valid   = a_valid;
    tl_h2d.a_opcode  = a_op;
    tl_h2d.a_size    = a_sz;
    tl_h2d.a_source  = a_src;
    tl_h2d.a_address = a_addr;
    tl_h2d.a_mask    = a_mask;
    tl_h2d.a_data    = a_data;
    tl_h2d.d_ready   = d_rdy;
  end

  student_tlul_sram_adapter #(.DEPTH(DEPTH), .ADDR_OFFSET(20)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_i        (tl_h2d),
    .tl_o        (tl_d2h),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM the adapter drives: byte-enabled write, one-cycle read latency.
  logic [31:0] sram [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) sram[i] <= 32'd0;
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] ref_mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'd0;

  function automatic bit ref_legal(logic [2:0] op, logic [1:0] sz, logic [31:0] addr, logic [3:0] mask);
    if (!(op == 3'd0 || op == 3'd1 || op == 3'd4)) return 1'b0;
    if (sz != 2'd2) return 1'b0;
    if (addr % 4 != 0) return 1'b0;
    if ((addr % 32'h0010_0000) >= 32'(4 * DEPTH)) return 1'b0;
    if (op == 3'd0 && mask != 4'hF) return 1'b0;
    if (op == 3'd1 && mask == 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  // pending response: becomes visible when m_count reaches zero
  bit          m_valid;
  int          m_count;
  logic [2:0]  m_op;
  bit          m_err;
  logic [31:0] m_data;
  logic [7:0]  m_src;
  logic [1:0]  m_size;

  always @(negedge clk) begin
    bit exp_ready, acc, lg, is_wr;
    int w, lat;
    exp_ready = !rst && !m_valid && (m_count == 0);
    check("a_ready", tl_d2h.a_ready, exp_ready);
    if (rst) begin
      check("rst_d_valid", tl_d2h.d_valid, 0);
      check("rst_d_error", tl_d2h.d_error, 0);
      check("rst_d_data", tl_d2h.d_data, 0);
      check("rst_d_source", tl_d2h.d_source, 0);
      check("rst_d_opcode", tl_d2h.d_opcode, 0);
      check("rst_mem_req", mem_req, 0);
      m_valid = 0;
      m_count = 0;
    end else begin
      acc   = a_valid && exp_ready;
      lg    = acc && ref_legal(a_op, a_sz, a_addr, a_mask);
      is_wr = (a_op == 3'd0) || (a_op == 3'd1);
      w     = (a_addr / 4) % DEPTH;
      check("mem_req", mem_req, lg);
      if (lg) begin
        check("mem_we", mem_we, is_wr);
        check("mem_addr", mem_addr, w);
        check("mem_be", mem_be, is_wr ? a_mask : 4'hF);
        if (is_wr) check("mem_wdata", mem_wdata, a_data);
      end
      check("d_valid", tl_d2h.d_valid, m_valid);
      if (m_valid) begin
        check("d_opcode", tl_d2h.d_opcode, m_op);
        check("d_error", tl_d2h.d_error, m_err);
        check("d_data", tl_d2h.d_data, m_data);
        check("d_source", tl_d2h.d_source, m_src);
        check("d_size", tl_d2h.d_size, m_size);
        check("d_param", tl_d2h.d_param, 0);
        check("d_sink", tl_d2h.d_sink, 0);
      end
      // advance to the next clock edge
      if (m_valid) begin
        if (d_rdy) m_valid = 0;
      end else if (m_count > 0) begin
        m_count--;
        if (m_count == 0) m_valid = 1;
      end else if (acc) begin
        m_src  = a_src;
        m_size = a_sz;
        m_err  = !lg;
        m_op   = (a_op == 3'd4) ? 3'd1 : 3'd0;
        m_data = (lg && a_op == 3'd4) ? ref_mem[w] : 32'd0;
        if (lg && is_wr)
          for (int b = 0; b < 4; b++)
            if (a_mask[b]) ref_mem[w][8*b +: 8] = a_data[8*b +: 8];
        lat = (lg && a_op == 3'd4) ? 2 : 1;
        m_count = lat - 1;
        if (m_count == 0) m_valid = 1;
      end
    end
  end

  // ---------------- host driver ----------------
  bit            l_req, l_we;
  logic [AW-1:0] l_addr;
  logic [3:0]    l_be;

  task automatic send(input logic [2:0] op, input logic [1:0] sz, input logic [31:0] addr,
                      input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                      output time t_acc);
    bit rdy, done;
    done = 0;
    t_acc = 0;
    a_op = op; a_sz = sz; a_addr = addr; a_mask = mask; a_data = data; a_src = src;
    a_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = tl_d2h.a_ready;
      l_req = mem_req; l_we = mem_we; l_addr = mem_addr; l_be = mem_be;
      @(posedge clk);
      if (rdy) begin
        done = 1;
        t_acc = $time;
      end
    end
    #1 a_valid = 1'b0;
    check("send_accepted", done, 1);
  endtask

  task automatic expect_resp(input int lat, input logic [2:0] op, input bit err,
                             input logic [31:0] data, input logic [7:0] src);
    bit seen;
    seen = 0;
    for (int k = 1; k <= 10 && !seen; k++) begin
      @(negedge clk);
      if (tl_d2h.d_valid) begin
        seen = 1;
        check("lit_latency", k, lat);
        check("lit_d_opcode", tl_d2h.d_opcode, op);
        check("lit_d_error", tl_d2h.d_error, err);
        check("lit_d_data", tl_d2h.d_data, data);
        check("lit_d_source", tl_d2h.d_source, src);
      end
    end
    check("lit_resp_seen", seen, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    d_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rnd_dready) d_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    time t, t2, hs_t;
    time ta [8];
    n_checks = 0; n_fail = 0;
    rnd_dready = 0;
    a_valid = 0; a_op = 0; a_sz = 0; a_src = 0; a_addr = 0; a_mask = 0; a_data = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    d_rdy = 1'b1;
    @(negedge clk);
    check("lit_rst_a_ready", tl_d2h.a_ready, 0);
    check("lit_rst_d_valid", tl_d2h.d_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("lit_a_ready_after_rst", tl_d2h.a_ready, 1);
    @(posedge clk); #1;

    // write then read back
    send(3'd0, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF, 8'd3, t);
    check("lit_wr_mem_req", l_req, 1);
    check("lit_wr_mem_we", l_we, 1);
    check("lit_wr_mem_addr", l_addr, 4);
    expect_resp(1, 3'd0, 0, 32'd0, 8'd3);
    send(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd5, t);
    check("lit_rd_mem_req", l_req, 1);
    check("lit_rd_mem_we", l_we, 0);
    expect_resp(2, 3'd1, 0, 32'hDEADBEEF, 8'd5);

    // partial write
    send(3'd1, 2'd2, 32'h20, 4'b0101, 32'h11223344, 8'd9, t);
    check("lit_pp_mem_be", l_be, 4'b0101);
    expect_resp(1, 3'd0, 0, 32'd0, 8'd9);

    // illegal requests
    send(3'd4, 2'd2, 32'h2, 4'hF, 32'h0, 8'd1, t);
    check("lit_err_misalign_req", l_req, 0);
    expect_resp(1, 3'd1, 1, 32'd0, 8'd1);
    send(3'd0, 2'd2, 32'h40, 4'h3, 32'h5555, 8'd2, t);
    check("lit_err_fullmask_req", l_req, 0);
    expect_resp(1, 3'd0, 1, 32'd0, 8'd2);
    send(3'd2, 2'd2, 32'h40, 4'hF, 32'h5555, 8'd4, t);
    check("lit_err_opcode_req", l_req, 0);
    expect_resp(1, 3'd0, 1, 32'd0, 8'd4);
    send(3'd4, 2'd1, 32'h40, 4'hF, 32'h0, 8'd6, t);
    check("lit_err_size_req", l_req, 0);
    expect_resp(1, 3'd1, 1, 32'd0, 8'd6);
    send(3'd0, 2'd2, 32'(4 * DEPTH), 4'hF, 32'h7777, 8'd8, t);
    check("lit_err_range_req", l_req, 0);
    expect_resp(1, 3'd0, 1, 32'd0, 8'd8);

    // backpressure: d_ready low for 5 response cycles, second request held
    d_rdy = 1'b0;
    send(3'd4, 2'd2, 32'h10, 4'hF, 32'h0, 8'd7, t);
    hs_t = 0;
    fork
      begin
        bit seen;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
          @(negedge clk);
          seen = tl_d2h.d_valid;
        end
        check("lit_bp_resp_seen", seen, 1);
        for (int i = 0; i < 5; i++) begin
          if (i > 0) @(negedge clk);
          check("lit_bp_d_valid", tl_d2h.d_valid, 1);
          check("lit_bp_d_data", tl_d2h.d_data, 32'hDEADBEEF);
          check("lit_bp_a_ready", tl_d2h.a_ready, 0);
          @(posedge clk);
        end
        #1 d_rdy = 1'b1;
        @(posedge clk);
        hs_t = $time;
      end
      send(3'd0, 2'd2, 32'h30, 4'hF, 32'hCAFEF00D, 8'd8, t2);
    join
    check("lit_bp_accept_after_hs", 32'(t2 - hs_t), 10);
    expect_resp(1, 3'd0, 0, 32'd0, 8'd8);

    // back-to-back, d_ready held high
    d_rdy = 1'b1;
    for (int i = 0; i < 4; i++)
      send(3'd0, 2'd2, 32'h100 + 32'(4 * i), 4'hF, 32'hA500_0000 + 32'(i), 8'(8'h10 + i), ta[i]);
    for (int i = 0; i < 4; i++)
      send(3'd4, 2'd2, 32'h100 + 32'(4 * i), 4'hF, 32'h0, 8'(8'h20 + i), ta[4 + i]);
    for (int i = 1; i < 4; i++) check("lit_wr_spacing", 32'(ta[i] - ta[i-1]), 20);
    for (int i = 5; i < 8; i++) check("lit_rd_spacing", 32'(ta[i] - ta[i-1]), 30);
    repeat (4) @(posedge clk);
    #1;

    // reset while a read is in flight
    send(3'd4, 2'd2, 32'h100, 4'hF, 32'h0, 8'd11, t);
    rst = 1'b1;
    @(negedge clk);
    check("lit_rdw_rst_d_valid", tl_d2h.d_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("lit_rdw_a_ready", tl_d2h.a_ready, 1);
    repeat (4) @(posedge clk);
    #1;

    // reset while a response is held
    d_rdy = 1'b0;
    send(3'd0, 2'd2, 32'h104, 4'hF, 32'h12345678, 8'd12, t);
    @(negedge clk);
    check("lit_resp_d_valid", tl_d2h.d_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("lit_resp_rst_d_valid", tl_d2h.d_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    d_rdy = 1'b1;
    @(negedge clk);
    check("lit_resp_a_ready", tl_d2h.a_ready, 1);
    repeat (4) @(posedge clk);
    #1;

    // randomized traffic, checked every cycle against the model
    rnd_dready = 1;
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [2:0]  op;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [3:0]  mask;
      r = $urandom_range(0, 99);
      if (r < 40)      op = 3'd4;
      else if (r < 65) op = 3'd0;
      else if (r < 90) op = 3'd1;
      else begin
        op = 3'($urandom_range(2, 7));
        if (op == 3'd4) op = 3'd3;
      end
      sz = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      addr = 32'($urandom_range(0, 63)) * 4;
      if ($urandom_range(0, 11) == 0) addr = addr | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 11) == 0) addr = addr | (32'($urandom_range(1, 255)) << 12);
      if (op == 3'd0) mask = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      else            mask = 4'($urandom_range(0, 15));
      send(op, sz, addr, mask, $urandom, 8'($urandom_range(0, 255)), t);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rnd_dready = 0;
    d_rdy = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
